// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types and geometry for the direct-mapped instruction cache
package icache_pkg;

    localparam int IIDX_W = 4;
    localparam int ITAG_W = 32 - IIDX_W - 2;

    typedef logic [31:0] word_t;

    // Fetch address split: tag | frame index | byte offset.
    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [1:0]        bytoff;
    } icachef_t;

    // One cache frame holds exactly one instruction word.
    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        word_t             data;
    } icache_frame_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    // Saturating increment used by both statistics counters.
    function automatic word_t sat_inc(input word_t v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-per-block instruction cache with single-word fill
module icache
    import icache_pkg::word_t, icache_pkg::icache_frame_t, icache_pkg::icache_state_t,
           icache_pkg::IDLE, icache_pkg::FILL, icache_pkg::sat_inc;
#(
    parameter int IIDX_W = icache_pkg::IIDX_W,
    parameter int ITAG_W = icache_pkg::ITAG_W
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int NFRAMES = 1 << IIDX_W;

    icache_frame_t     frames [NFRAMES];
    icache_state_t     state;
    icache_state_t     state_next;
    word_t             miss_addr;
    word_t             hit_cnt;
    word_t             miss_cnt;

    logic [ITAG_W-1:0] req_tag;
    logic [IIDX_W-1:0] req_idx;
    logic [ITAG_W-1:0] miss_tag;
    logic [IIDX_W-1:0] miss_idx;
    logic              lookup_hit;
    logic              fill_done;
    logic              count_hit;
    logic              count_miss;

    assign req_tag  = imemaddr[31:IIDX_W+2];
    assign req_idx  = imemaddr[IIDX_W+1:2];
    assign miss_tag = miss_addr[31:IIDX_W+2];
    assign miss_idx = miss_addr[IIDX_W+1:2];

    assign lookup_hit = imemREN && frames[req_idx].valid && (frames[req_idx].tag == req_tag);
    assign fill_done  = (state == FILL) && !iwait;

    assign hit_count  = hit_cnt;
    assign miss_count = miss_cnt;

    // State register; an abandoned fill simply returns to IDLE on reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Lookup in IDLE, fill request and fill-complete bypass in FILL.
    always_comb begin
        state_next = state;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        count_hit  = 1'b0;
        count_miss = 1'b0;
        case (state)
            IDLE: begin
                if (imemREN) begin
                    if (lookup_hit) begin
                        ihit      = 1'b1;
                        imemload  = frames[req_idx].data;
                        count_hit = 1'b1;
                    end else begin
                        count_miss = 1'b1;
                        state_next = FILL;
                    end
                end
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = miss_addr;
                if (!iwait) begin
                    state_next = IDLE;
                    // Forward the arriving word only if the fetch still wants it.
                    if (imemREN && (imemaddr == miss_addr)) begin
                        ihit     = 1'b1;
                        imemload = iload;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the missing address; it drives iaddr unchanged for the whole fill.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            miss_addr <= '0;
        end else if (count_miss) begin
            miss_addr <= imemaddr;
        end
    end

    // Frame array: cleared on reset, written only when a fill completes.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NFRAMES; i++) begin
                frames[i] <= '0;
            end
        end else if (fill_done) begin
            frames[miss_idx] <= '{valid: 1'b1, tag: miss_tag, data: iload};
        end
    end

    // Saturating hit/miss statistics; the fill bypass is not counted as a hit.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (count_hit) begin
                hit_cnt <= sat_inc(hit_cnt);
            end
            if (count_miss) begin
                miss_cnt <= sat_inc(miss_cnt);
            end
        end
    end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - scoreboard bench for icache with randomized fetches and a memory responder
module tb_icache;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    icache dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] sb_q[$];

    // Reference model: which block each index holds, plus expected counters.
    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    // Memory responder state.
    int          next_waits = 0;
    int          fill_cycles = 0;
    logic [31:0] fill_addr = 0;
    bit          in_fill = 0;
    bit          done_prev = 0;
    int          left = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h8C22_0004;
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0000;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[a[5:2]] && (m_tag[a[5:2]] == a[31:6]);
    endfunction

    function automatic void model_fill(input logic [31:0] a);
        m_valid[a[5:2]] = 1'b1;
        m_tag[a[5:2]]   = a[31:6];
    endfunction

    function automatic void model_count(input bit hit);
        if (hit) begin
            if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 1;
        end else begin
            if (m_misses != 32'hFFFF_FFFF) m_misses = m_misses + 1;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_counts(input string name);
        check({name, "_hit_count"}, hit_count, m_hits);
        check({name, "_miss_count"}, miss_count, m_misses);
    endtask

    // Monitor: every ihit must match the oldest outstanding expected word.
    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (ihit === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ihit: imemload %h with nothing expected", imemload);
                end else begin
                    check("imemload", imemload, sb_q.pop_front());
                end
            end else begin
                check("imemload_zero_without_ihit", imemload, 32'h0);
            end
        end
    end

    // Memory responder: holds iwait for the chosen number of cycles, then returns the word.
    initial begin
        iwait = 1'b0;
        iload = '0;
        forever begin
            @(negedge CLK);
            if (nRST !== 1'b1) begin
                in_fill   = 0;
                done_prev = 0;
                iwait     = 1'b0;
                iload     = '0;
            end else begin
                if (done_prev) check("iren_drops_after_fill", {31'b0, iREN}, 32'h0);
                done_prev = 0;
                if (iREN && !in_fill) begin
                    in_fill     = 1;
                    left        = next_waits;
                    fill_cycles = 0;
                    fill_addr   = iaddr;
                end
                if (in_fill) begin
                    fill_cycles++;
                    check("iaddr_stable", iaddr, fill_addr);
                    if (left > 0) begin
                        left--;
                        iwait = 1'b1;
                        iload = $urandom;
                    end else begin
                        iwait     = 1'b0;
                        iload     = mem_word(iaddr);
                        in_fill   = 0;
                        done_prev = 1;
                    end
                end else begin
                    iwait = 1'($urandom_range(0, 1));
                    iload = $urandom;
                end
            end
        end
    end

    task automatic wait_ihit(output int cyc);
        cyc = 1;
        #3;
        while (ihit !== 1'b1 && cyc < 40) begin
            @(negedge CLK);
            #3;
            cyc++;
        end
    endtask

    task automatic fetch(input logic [31:0] a, input int waits, input string name);
        bit exp_hit;
        int cyc;
        exp_hit    = model_hit(a);
        next_waits = waits;
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = a;
        sb_q.push_back(mem_word(a));
        wait_ihit(cyc);
        check({name, "_ihit"}, {31'b0, ihit}, 32'h1);
        check({name, "_latency"}, cyc, exp_hit ? 1 : waits + 2);
        if (!exp_hit) begin
            check({name, "_fill_addr"}, fill_addr, a);
            check({name, "_fill_cycles"}, fill_cycles, waits + 1);
            model_fill(a);
        end
        model_count(exp_hit);
        @(negedge CLK);
        imemREN = 1'b0;
        #3;
        check_counts(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [31:0] a;
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = '0;
        model_reset();
        repeat (2) @(negedge CLK);
        #2;
        check("reset_ihit", {31'b0, ihit}, 32'h0);
        check("reset_iren", {31'b0, iREN}, 32'h0);
        check("reset_iaddr", iaddr, 32'h0);
        check_counts("reset");
        @(negedge CLK);
        nRST = 1'b1;

        // Cold miss with three wait cycles, then a repeat hit.
        fetch(32'h0000_0040, 3, "cold_miss");
        check("cold_miss_count", miss_count, 32'd1);
        fetch(32'h0000_0040, 0, "repeat_hit");
        check("repeat_hit_count", hit_count, 32'd1);

        // Conflicting tags on index 0 evict each other.
        fetch(32'h0000_0440, 1, "conflict_b");
        fetch(32'h0000_0040, 0, "conflict_a");
        check("conflict_miss_count", miss_count, 32'd3);

        // Address changes mid-fill: 0x80 still fills, 0x84 is looked up afterwards.
        next_waits = 2;
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0080;
        model_count(model_hit(32'h0000_0080));
        @(negedge CLK);
        imemaddr = 32'h0000_0084;
        sb_q.push_back(mem_word(32'h0000_0084));
        #3;
        next_waits = 0;
        check("midfill_no_ihit", {31'b0, ihit}, 32'h0);
        #2;
        @(negedge CLK);
        wait_ihit(cyc);
        check("midfill_84_ihit", {31'b0, ihit}, 32'h1);
        check("midfill_84_latency", cyc, 4);
        model_fill(32'h0000_0080);
        model_count(model_hit(32'h0000_0084));
        model_fill(32'h0000_0084);
        @(negedge CLK);
        imemREN = 1'b0;
        #3;
        check_counts("midfill");
        fetch(32'h0000_0080, 0, "midfill_refetch_80");

        // Reset in the middle of a fill drops iREN immediately and clears the frames.
        next_waits = 3;
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0100;
        @(negedge CLK);
        #1;
        check("pre_reset_iren", {31'b0, iREN}, 32'h1);
        nRST = 1'b0;
        #1;
        check("async_reset_iren", {31'b0, iREN}, 32'h0);
        check("async_reset_iaddr", iaddr, 32'h0);
        imemREN = 1'b0;
        model_reset();
        @(negedge CLK);
        #3;
        check_counts("after_reset");
        @(negedge CLK);
        nRST = 1'b1;
        fetch(32'h0000_0040, 1, "post_reset_miss");

        // Hit counter saturates.
        @(negedge CLK);
        force dut.hit_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.hit_cnt;
        m_hits = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) fetch(32'h0000_0040, 0, "sat_hit");
        check("sat_hit_count", hit_count, 32'hFFFF_FFFF);

        // Randomized fetch stream over a small set of tags so hits and conflicts mix.
        for (int i = 0; i < 120; i++) begin
            a = ({30'($urandom_range(0, 2)), 4'($urandom_range(0, 15))}) << 2;
            fetch(a, $urandom_range(0, 3), "rand");
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        repeat (2) @(negedge CLK);
        check("scoreboard_drained", sb_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
